// File: rtl/gxor_pkg.sv
// Shared types and constants for the streaming XOR checksum block.
package gxor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/gxor_n.sv
// Vector form of the XOR gate: bitwise a ^ b over WIDTH bits.
module gxor_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/gxor_checksum.sv
// Streaming XOR checksum generator/checker with frame length tracking
// and a held result handshake.
module gxor_checksum
  import gxor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic             out_err,
  output logic [LW-1:0]    out_len,
  output logic             out_len_err
);

  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic          ONE_WORD  = (MAX_LEN == 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LW-1:0]    len_q, len_d;
  logic             mode_q, mode_d;
  logic             len_err_q, len_err_d;
  logic [WIDTH-1:0] acc_xor;
  logic [LW-1:0]    len_inc;
  logic             accept;

  gxor_n #(.WIDTH(WIDTH)) u_xor (
    .a (acc_q),
    .b (in_data),
    .y (acc_xor)
  );

  assign in_ready = (state_q != DONE);
  assign accept   = in_valid && in_ready;
  assign len_inc  = len_q + LW'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    len_d     = len_q;
    mode_d    = mode_q;
    len_err_d = len_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d     = in_data;
          len_d     = LW'(1);
          mode_d    = mode;
          len_err_d = ONE_WORD && !in_last;
          state_d   = (in_last || ONE_WORD) ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d = acc_xor;
          len_d = len_inc;
          // A frame that fills up without in_last is flagged as a length error.
          if (in_last || (len_inc == MAX_LEN_L)) begin
            len_err_d = !in_last;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      len_q     <= '0;
      mode_q    <= MODE_GEN;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      len_err_q <= len_err_d;
    end
  end

  assign out_valid   = (state_q == DONE);
  assign out_sum     = acc_q;
  assign out_parity  = ^acc_q;
  assign out_err     = (mode_q == MODE_CHK) && (acc_q != '0);
  assign out_len     = len_q;
  assign out_len_err = len_err_q;

endmodule

// File: tb/tb_gxor_checksum.sv
// Directed testbench for gxor_checksum with WIDTH=8, MAX_LEN=4.
module tb_gxor_checksum;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_parity;
  logic             out_err;
  logic [LW-1:0]    out_len;
  logic             out_len_err;

  int n_tests = 0;
  int n_fail  = 0;

  gxor_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .mode        (mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_parity  (out_parity),
    .out_err     (out_err),
    .out_len     (out_len),
    .out_len_err (out_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] s, input logic p,
                         input logic e, input logic [LW-1:0] l, input logic le, input logic r);
    chk({tag, ".valid"},   out_valid,   v);
    chk({tag, ".sum"},     out_sum,     s);
    chk({tag, ".parity"},  out_parity,  p);
    chk({tag, ".err"},     out_err,     e);
    chk({tag, ".len"},     out_len,     l);
    chk({tag, ".len_err"}, out_len_err, le);
    chk({tag, ".ready"},   in_ready,    r);
  endtask

  task automatic word(input logic [7:0] d, input logic l, input logic m);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    mode     = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      mode = ~mode;
      @(posedge clk); #1;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 8'h00, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Generate mode, back-to-back
    word(8'h12, 0, 0);
    chk("gen.busy", out_valid, 0);
    word(8'h34, 0, 0);
    word(8'h56, 1, 0);
    chk_out("gen", 1, 8'h70, 1, 0, 3, 0, 0);
    release_result();
    chk("gen.rel.valid", out_valid, 0);
    chk("gen.rel.ready", in_ready, 1);

    // Check mode, pass then fail
    word(8'h12, 0, 1);
    word(8'h34, 0, 1);
    word(8'h26, 1, 1);
    chk_out("chk_pass", 1, 8'h00, 0, 0, 3, 0, 0);
    release_result();
    word(8'h12, 0, 1);
    word(8'h34, 0, 1);
    word(8'h27, 1, 1);
    chk_out("chk_fail", 1, 8'h01, 1, 1, 3, 0, 0);
    release_result();

    // Frame force-closed at MAX_LEN
    word(8'h01, 0, 0);
    word(8'h02, 0, 0);
    word(8'h04, 0, 0);
    chk("maxlen.busy", out_valid, 0);
    word(8'h08, 0, 0);
    chk_out("maxlen", 1, 8'h0F, 0, 0, 4, 1, 0);
    release_result();

    // Last word exactly at MAX_LEN is not a length error
    word(8'h01, 0, 0);
    word(8'h02, 0, 0);
    word(8'h04, 0, 0);
    word(8'h08, 1, 0);
    chk_out("maxlen_last", 1, 8'h0F, 0, 0, 4, 0, 0);
    release_result();

    // Single word with backpressure; offered words in DONE must be ignored
    word(8'hA5, 1, 0);
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1; mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_out("hold", 1, 8'hA5, 0, 0, 1, 0, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    release_result();
    chk("hold.rel.valid", out_valid, 0);
    chk("hold.rel.ready", in_ready, 1);

    // Gaps with mode toggling; mode latched from the first word
    word(8'h12, 0, 1);
    gap(3);
    word(8'h34, 0, 0);
    gap(3);
    chk("gaps.busy", out_valid, 0);
    word(8'h27, 1, 0);
    chk_out("gaps", 1, 8'h01, 1, 1, 3, 0, 0);
    release_result();

    // Asynchronous reset mid-frame
    word(8'h3C, 0, 1);
    word(8'hC3, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 0, 8'h00, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.after", out_valid, 0);
    word(8'h55, 1, 0);
    chk_out("post_rst", 1, 8'h55, 0, 0, 1, 0, 0);
    release_result();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
